// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction
// field positions, FSM state encodings and field extraction helpers.
package instr_sequencer_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD       = 6'd0;
    localparam logic [5:0] OP_SUB       = 6'd1;
    localparam logic [5:0] OP_SHL       = 6'd2;
    localparam logic [5:0] OP_SHR       = 6'd3;
    localparam logic [5:0] OP_LOAD      = 6'd5;
    localparam logic [5:0] OP_CMP_EQ    = 6'd8;
    localparam logic [5:0] OP_CMP_LAST  = 6'd12;
    localparam logic [5:0] OP_FLAG_HOLD = 6'd13;
    localparam logic [5:0] OP_JMP       = 6'd14;
    localparam logic [5:0] OP_JMPF      = 6'd15;
    localparam logic [5:0] OP_ILL_FIRST = 6'd16;
    localparam logic [5:0] OP_ILL_LAST  = 6'd62;
    localparam logic [5:0] OP_HALT      = 6'd63;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 18;
    localparam int HL_BIT  = 17;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH_IDLE = 3'd0;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
    localparam logic [2:0] ST_DECODE     = 3'd2;
    localparam logic [2:0] ST_EXECUTE    = 3'd3;
    localparam logic [2:0] ST_WRITEBACK  = 3'd4;
    localparam logic [2:0] ST_HALTED     = 3'd5;

    function automatic logic [5:0] ir_op(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [3:0] ir_rd(input logic [31:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] ir_rs(input logic [31:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_field_decode.sv
// instr_field_decode: combinational opcode classifier.
//   op_i            : opcode field of the instruction register
//   writes_rf_o     : result is written back to the register file (ops 0-5)
//   updates_flags_o : F1/F2 shift in the ALU compare result (ops 8-12)
//   is_branch_o     : PC may be redirected by the ALU (ops 14, 15)
//   is_halt_o       : HALT (op 63)
//   is_illegal_o    : undefined opcode (ops 16-62)
module instr_field_decode
    import instr_sequencer_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       writes_rf_o,
    output logic       updates_flags_o,
    output logic       is_branch_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    // Classify the opcode; every unlisted op falls through as a plain NOP.
    always_comb begin
        writes_rf_o     = 1'b0;
        updates_flags_o = 1'b0;
        is_branch_o     = 1'b0;
        is_halt_o       = 1'b0;
        is_illegal_o    = 1'b0;
        if (op_i <= OP_LOAD) begin
            writes_rf_o = 1'b1;
        end else if ((op_i >= OP_CMP_EQ) && (op_i <= OP_CMP_LAST)) begin
            updates_flags_o = 1'b1;
        end else if ((op_i == OP_JMP) || (op_i == OP_JMPF)) begin
            is_branch_o = 1'b1;
        end else if (op_i == OP_HALT) begin
            is_halt_o = 1'b1;
        end else if ((op_i >= OP_ILL_FIRST) && (op_i <= OP_ILL_LAST)) begin
            is_illegal_o = 1'b1;
        end else begin
            writes_rf_o = 1'b0;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute/write-back control unit for the ALU.
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   run                     : permits a new fetch
//   imem_req/addr/valid/data: instruction memory request/valid handshake
//   rf_raddr_a/b            : register-file read selects (rd, rs)
//   rf_we/waddr/wdata       : register-file write-back port
//   alu_*  (out)            : opcode, immediate, half select and flags to ALU
//   alu_c/f3/addrch/naddr   : ALU result, flag, branch-taken and target
//   pc, halted, illegal     : status
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [5:0]  alu_instr,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_f1,
    output logic        alu_f2,
    input  logic [31:0] alu_c,
    input  logic        alu_f3,
    input  logic        alu_addrch,
    input  logic [31:0] alu_naddr,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        f1_q, f1_d;
    logic        f2_q, f2_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic dec_writes_rf_s, dec_updates_flags_s, dec_is_branch_s;
    logic dec_is_halt_s, dec_is_illegal_s;
    logic ir_unused_s;

    instr_field_decode u_decode (
        .op_i            (ir_op(ir_q)),
        .writes_rf_o     (dec_writes_rf_s),
        .updates_flags_o (dec_updates_flags_s),
        .is_branch_o     (dec_is_branch_s),
        .is_halt_o       (dec_is_halt_s),
        .is_illegal_o    (dec_is_illegal_s)
    );

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        req_d     = req_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH_IDLE: begin
                if (run) begin
                    req_d   = 1'b1;
                    state_d = ST_FETCH_WAIT;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_FETCH_WAIT: begin
                // run is deliberately not looked at: an issued fetch completes.
                if (imem_valid) begin
                    ir_d    = imem_data;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (dec_is_halt_s) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else begin
                    state_d = ST_WRITEBACK;
                    if (dec_is_branch_s && alu_addrch) begin
                        pc_d = alu_naddr;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                    if (dec_writes_rf_s) begin
                        we_d    = 1'b1;
                        waddr_d = ir_rd(ir_q);
                        wdata_d = alu_c;
                    end else begin
                        we_d = 1'b0;
                    end
                    if (dec_updates_flags_s) begin
                        f2_d = f1_q;
                        f1_d = alu_f3;
                    end else begin
                        f2_d = f2_q;
                    end
                    if (dec_is_illegal_s) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d = illegal_q;
                    end
                end
            end
            ST_WRITEBACK: begin
                we_d    = 1'b0;
                state_d = ST_FETCH_IDLE;
            end
            ST_HALTED: begin
                req_d = 1'b0;
                we_d  = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_FETCH_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0000;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= 4'd0;
            wdata_q   <= 32'h0000_0000;
            f1_q      <= 1'b0;
            f2_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            req_q     <= req_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // ALU controls come straight from IR, so they hold through EXECUTE and
    // read as zero after reset.
    assign alu_instr   = ir_op(ir_q);
    assign alu_value   = ir_q[IMM_MSB:IMM_LSB];
    assign alu_highlow = ir_q[HL_BIT];
    assign rf_raddr_a  = ir_rd(ir_q);
    assign rf_raddr_b  = ir_rs(ir_q);
    assign ir_unused_s = ir_q[16];

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign alu_f1    = f1_q;
    assign alu_f2    = f2_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/control unit that drives the ALU's operand, opcode and flag inputs and consumes its result, flag and branch outputs.
- Fetches 32-bit instruction words over a request/valid memory handshake, decodes them, and sequences register-file reads and write-back.
- Owns the program counter and the F1/F2 flag registers.
- Sits between instruction memory, the register file and the ALU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 1, PC increment per sequential instruction (word addressing)

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- run  input  1  permits a new fetch when high
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address; equals pc
- imem_valid  input  1  fetch data valid
- imem_data  input  32  instruction word
- rf_raddr_a  output  4  register-file read select for ALU A (rd field)
- rf_raddr_b  output  4  register-file read select for ALU B (rs field)
- rf_we  output  1  register-file write enable
- rf_waddr  output  4  write-back register
- rf_wdata  output  32  write-back data
- alu_instr  output  6  opcode to ALU
- alu_value  output  16  immediate to ALU
- alu_highlow  output  1  immediate half select to ALU
- alu_f1  output  1  flag F1 to ALU
- alu_f2  output  1  flag F2 to ALU
- alu_c  input  32  ALU result
- alu_f3  input  1  ALU compare/flag result
- alu_addrch  input  1  ALU branch-taken
- alu_naddr  input  32  ALU branch target
- pc  output  32  current program counter
- halted  output  1  high in HALTED state
- illegal  output  1  sticky; set on an undefined opcode

Behaviour:
- Instruction format: [31:26] op, [25:22] rd, [21:18] rs, [17] highlow, [16] ignored, [15:0] imm.
- Reset (asynchronous, while reset_n low):
  - State = FETCH_IDLE, pc = RESET_PC.
  - F1 = F2 = 0; halted = 0; illegal = 0.
  - imem_req = 0, rf_we = 0.
  - alu_instr = 0, alu_value = 0, alu_highlow = 0; IR cleared to 0.
- States: FETCH_IDLE, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, HALTED.
- FETCH_IDLE: if run, assert imem_req next cycle and go to FETCH_WAIT; otherwise stay.
- FETCH_WAIT:
  - imem_req held high and imem_addr stable until imem_valid.
  - On the imem_valid edge, capture imem_data into IR, drop imem_req the next cycle, go to DECODE.
  - imem_valid outside FETCH_WAIT is ignored.
  - run going low after a request has no effect; the fetch completes.
- DECODE (1 cycle):
  - Drive rf_raddr_a = rd and rf_raddr_b = rs.
  - Drive alu_instr, alu_value and alu_highlow from IR; these hold through EXECUTE.
- EXECUTE (1 cycle): sample alu_c, alu_f3, alu_addrch and alu_naddr at the closing edge.
  - ops 0–5: result latched for write-back.
  - ops 8–12: F2 <= old F1, F1 <= alu_f3.
  - op 13: flags unchanged (the ALU's clock-qualified term is not sampled).
  - ops 14, 15: if alu_addrch, pc <= alu_naddr; otherwise pc <= pc + PC_STEP.
  - ops 6, 7: no side effects beyond the PC increment.
  - op 63: HALT. Go to HALTED; pc is not incremented.
  - ops 16–62: illegal <= 1; executed as a NOP.
  - All non-branch, non-halt ops: pc <= pc + PC_STEP, wrapping modulo 2^32.
- WRITEBACK (1 cycle): rf_we = 1 only for ops 0–5, with rf_waddr = rd and rf_wdata = latched alu_c. Then go to FETCH_IDLE.
- Latency: minimum 5 cycles per instruction (idle, fetch with zero wait, decode, execute, writeback). Each extra memory wait cycle adds 1.
- HALTED:
  - halted = 1; all request and write outputs are 0.
  - Exit only via reset; run is ignored.
- rf_we is never asserted outside WRITEBACK. imem_req is never asserted outside FETCH_WAIT.
- Reset mid-fetch drops imem_req immediately. A stale imem_valid after reset release is ignored unless in FETCH_WAIT with a new request outstanding.

Decomposition:
- Shared package holds:
  - opcode constants: OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_LOAD=5, OP_CMP_EQ=8 … OP_JMP=14, OP_JMPF=15, OP_HALT=63
  - the instruction field bit positions
  - the state enumeration
- One natural sub-module: instr_field_decode. It is combinational, decoding IR into writes_rf, updates_flags, is_branch, is_halt and is_illegal.

Test Plan:
1. Reset with RESET_PC=0x10, run=1, memory returns 0x0000_0000 (ADD r0,r0) with zero wait -> imem_addr=0x10; rf_we pulse at cycle 5 with rf_waddr=0; pc=0x11.
2. LOAD op5, rd=3, highlow=1, imm=0xBEEF; ALU returns 0xBEEF1234 -> alu_value=0xBEEF and alu_highlow=1 during DECODE/EXECUTE; rf_wdata=0xBEEF1234, rf_waddr=3.
3. CMP_EQ op8 with alu_f3=1, then op8 with alu_f3=0 -> F1=1,F2=0 after the first; F1=0,F2=1 after the second; rf_we never asserted.
4. op15 with alu_addrch=1, alu_naddr=0x200 -> next imem_addr=0x200; repeat with alu_addrch=0 at pc=0xFFFF_FFFF -> pc wraps to 0.
5. Memory inserts 3 wait cycles -> imem_req held high and imem_addr stable for 4 cycles; a spurious imem_valid during DECODE is ignored.
6. op 20, then op 63 -> illegal=1 and pc advanced by 1; then halted=1, imem_req stays 0 with run=1; reset_n low mid-FETCH_WAIT clears imem_req and illegal asynchronously.
